// File: rtl/graphics_control.sv
// graphics_control: sequencing FSM for the 8x8 tile-drawing datapath.
// Accepts one tile request at a time on a ready/valid handshake and clamps
// the tile so that it stays inside the 160x120 screen. Each tile is a
// one-cycle load followed by 64 plotted pixels.
// A flash request first draws the tile in white. The tile then holds for
// FLASH_HOLD cycles, or less if cancelled, and is redrawn in its real colour.
// Every output is registered. Each output is decoded from the next state, so
// an output register always agrees with the state register that is loaded
// on the same edge.

module graphics_control #(
  parameter int FLASH_HOLD = 12500000,
  parameter int HOLD_W     = 24
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       req,
  input  logic [7:0] req_x,
  input  logic [6:0] req_y,
  input  logic [2:0] req_colour,
  input  logic       req_flash,
  input  logic       cancel,
  output logic       ready,
  output logic       done,
  output logic       load,
  output logic       enable,
  output logic       flash,
  output logic [7:0] x_in,
  output logic [7:0] y_in,
  output logic [2:0] colour_in,
  output logic       plot
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_DRAW = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // The largest top-left corner that still fits an 8x8 tile on 160x120.
  localparam logic [7:0] X_MAX    = 8'd152;
  localparam logic [6:0] Y_MAX    = 7'd112;
  localparam logic [5:0] PIX_LAST = 6'd63;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FLASH_HOLD - 1);

  // The x clamp is an 8-bit compare against the last legal tile column.
  function automatic logic [7:0] clamp_x(input logic [7:0] x);
    clamp_x = (x > X_MAX) ? X_MAX : x;
  endfunction

  // The y clamp is a 7-bit compare against the last legal tile row.
  function automatic logic [6:0] clamp_y(input logic [6:0] y);
    clamp_y = (y > Y_MAX) ? Y_MAX : y;
  endfunction

  logic [2:0]        state_r, nxt_state_s;
  logic [5:0]        pix_r, nxt_pix_s;
  logic [HOLD_W-1:0] hold_r, nxt_hold_s;
  logic              pass_r, nxt_pass_s;
  logic [7:0]        cx_r, nxt_cx_s;
  logic [6:0]        cy_r, nxt_cy_s;
  logic [2:0]        ccol_r, nxt_ccol_s;
  logic              cfl_r, nxt_cfl_s;

  logic              ready_r, ready_s;
  logic              done_r, done_s;
  logic              load_r, load_s;
  logic              enable_r, enable_s;
  logic              flash_r, flash_s;
  logic              plot_r, plot_s;
  logic [7:0]        x_in_r, x_in_s;
  logic [7:0]        y_in_r, y_in_s;
  logic [2:0]        colour_in_r, colour_in_s;

  // Next-state logic: request capture, pixel and hold counting, pass tracking.
  always_comb begin
    nxt_state_s = state_r;
    nxt_pix_s   = pix_r;
    nxt_hold_s  = hold_r;
    nxt_pass_s  = pass_r;
    nxt_cx_s    = cx_r;
    nxt_cy_s    = cy_r;
    nxt_ccol_s  = ccol_r;
    nxt_cfl_s   = cfl_r;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          nxt_state_s = ST_LOAD;
          nxt_cx_s    = clamp_x(req_x);
          nxt_cy_s    = clamp_y(req_y);
          nxt_ccol_s  = req_colour;
          nxt_cfl_s   = req_flash;
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        nxt_pix_s   = 6'd0;
        nxt_state_s = ST_DRAW;
      end
      ST_DRAW: begin
        if (pix_r == PIX_LAST) begin
          if (!pass_r && cfl_r) begin
            nxt_state_s = ST_HOLD;
            nxt_hold_s  = '0;
            nxt_pass_s  = 1'b1;
          end else begin
            nxt_state_s = ST_DONE;
          end
        end else begin
          nxt_pix_s = pix_r + 6'd1;
        end
      end
      ST_HOLD: begin
        if ((hold_r == HOLD_LAST) || cancel) begin
          nxt_state_s = ST_LOAD;
        end else begin
          nxt_hold_s = hold_r + HOLD_W'(1);
        end
      end
      ST_DONE: begin
        nxt_pass_s  = 1'b0;
        nxt_state_s = ST_IDLE;
      end
      default: begin
        nxt_pass_s  = 1'b0;
        nxt_state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the output flops line up with state_r.
  always_comb begin
    ready_s     = 1'b0;
    done_s      = 1'b0;
    load_s      = 1'b0;
    enable_s    = 1'b0;
    flash_s     = 1'b0;
    plot_s      = 1'b0;
    x_in_s      = 8'd0;
    y_in_s      = 8'd0;
    colour_in_s = 3'd0;
    case (nxt_state_s)
      ST_IDLE: begin
        ready_s = 1'b1;
      end
      ST_LOAD: begin
        load_s      = 1'b1;
        enable_s    = 1'b1;
        flash_s     = !nxt_pass_s && nxt_cfl_s;
        x_in_s      = nxt_cx_s;
        y_in_s      = {1'b0, nxt_cy_s};
        colour_in_s = nxt_ccol_s;
      end
      ST_DRAW: begin
        enable_s    = 1'b1;
        plot_s      = 1'b1;
        x_in_s      = nxt_cx_s;
        y_in_s      = {1'b0, nxt_cy_s};
        colour_in_s = nxt_ccol_s;
      end
      ST_HOLD: begin
        ready_s = 1'b0;
      end
      ST_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        ready_s = 1'b0;
      end
    endcase
  end

  // State and captured-request registers; reset drops any tile in progress.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      pix_r   <= 6'd0;
      hold_r  <= '0;
      pass_r  <= 1'b0;
      cx_r    <= 8'd0;
      cy_r    <= 7'd0;
      ccol_r  <= 3'd0;
      cfl_r   <= 1'b0;
    end else begin
      state_r <= nxt_state_s;
      pix_r   <= nxt_pix_s;
      hold_r  <= nxt_hold_s;
      pass_r  <= nxt_pass_s;
      cx_r    <= nxt_cx_s;
      cy_r    <= nxt_cy_s;
      ccol_r  <= nxt_ccol_s;
      cfl_r   <= nxt_cfl_s;
    end
  end

  // Output registers; in reset only ready is high.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ready_r     <= 1'b1;
      done_r      <= 1'b0;
      load_r      <= 1'b0;
      enable_r    <= 1'b0;
      flash_r     <= 1'b0;
      plot_r      <= 1'b0;
      x_in_r      <= 8'd0;
      y_in_r      <= 8'd0;
      colour_in_r <= 3'd0;
    end else begin
      ready_r     <= ready_s;
      done_r      <= done_s;
      load_r      <= load_s;
      enable_r    <= enable_s;
      flash_r     <= flash_s;
      plot_r      <= plot_s;
      x_in_r      <= x_in_s;
      y_in_r      <= y_in_s;
      colour_in_r <= colour_in_s;
    end
  end

  assign ready     = ready_r;
  assign done      = done_r;
  assign load      = load_r;
  assign enable    = enable_r;
  assign flash     = flash_r;
  assign plot      = plot_r;
  assign x_in      = x_in_r;
  assign y_in      = y_in_r;
  assign colour_in = colour_in_r;

  graphics_control_checker u_checker (
    .clock  (clock),
    .resetn (resetn),
    .ready  (ready_r),
    .done   (done_r),
    .load   (load_r),
    .enable (enable_r),
    .plot   (plot_r),
    .x_in   (x_in_r),
    .y_in   (y_in_r)
  );

endmodule

// graphics_control_checker: output-contention and range invariants.
module graphics_control_checker (
  input logic       clock,
  input logic       resetn,
  input logic       ready,
  input logic       done,
  input logic       load,
  input logic       enable,
  input logic       plot,
  input logic [7:0] x_in,
  input logic [7:0] y_in
);

  // Check the invariants on every clock edge outside reset.
  always @(posedge clock) begin
    if (resetn) begin
      assert (!(load && plot));
      assert (!plot || enable);
      assert (y_in[7] == 1'b0);
      assert (x_in <= 8'd152);
      assert (y_in <= 8'd112);
      assert (!ready || !(load || plot || done || enable));
    end
  end

endmodule
